// File: rtl/bpf_forwarder.sv
// Forwarder port consumer: reads an accepted packet out of packetmem word by word
// and replays it as an AXI-Stream master, then releases the buffer with forwarder_done.
module bpf_forwarder #(
  parameter int PACKET_BYTE_ADDR_WIDTH = 12,
  parameter int SNOOP_FWD_ADDR_WIDTH   = 9,
  localparam int AW = SNOOP_FWD_ADDR_WIDTH,
  localparam int DW = 2 ** (3 + PACKET_BYTE_ADDR_WIDTH - SNOOP_FWD_ADDR_WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ready_for_forwarder,
  input  logic [AW-1:0] len_to_forwarder,
  output logic [AW-1:0] forwarder_rd_addr,
  output logic          forwarder_rd_en,
  input  logic [DW-1:0] forwarder_rd_data,
  output logic          forwarder_done,
  output logic [DW-1:0] m_axis_tdata,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic          m_axis_tlast,
  output logic [31:0]   pkt_count
);

  // state  | meaning
  // IDLE   | waiting for packetmem to offer a packet
  // LATCH  | capture length, clear word counters
  // STREAM | issue reads, emit beats until the tlast beat handshakes
  // DONE   | one-cycle forwarder_done, count the packet
  // HOLD   | let packetmem drop ready_for_forwarder before sampling again
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LATCH  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;

  logic [2:0]    state;
  logic [AW-1:0] len_q;
  logic [AW-1:0] issued;
  logic [AW-1:0] sent;
  logic          inflight;
  logic [DW-1:0] fifo_mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    fifo_count;
  logic          beat;
  logic [2:0]    occ;

  assign m_axis_tvalid = (fifo_count != 2'd0);
  assign m_axis_tdata  = m_axis_tvalid ? fifo_mem[rd_ptr] : '0;
  assign m_axis_tlast  = m_axis_tvalid && (sent == len_q - AW'(1));
  assign beat          = m_axis_tvalid && m_axis_tready;

  // Occupancy credits the slot freed by this cycle's beat, so a steady tready=1
  // stream issues one read per cycle while the FIFO still never exceeds two words.
  assign occ = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, beat};

  assign forwarder_rd_en   = (state == S_STREAM) && (issued < len_q) && (occ < 3'd2);
  assign forwarder_rd_addr = issued;
  assign forwarder_done    = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (inflight) begin
      fifo_mem[wr_ptr] <= forwarder_rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      len_q      <= '0;
      issued     <= '0;
      sent       <= '0;
      inflight   <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
      pkt_count  <= 32'd0;
    end else begin
      inflight   <= forwarder_rd_en;
      fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, beat};
      if (inflight) begin
        wr_ptr <= ~wr_ptr;
      end
      if (beat) begin
        rd_ptr <= ~rd_ptr;
        sent   <= sent + AW'(1);
      end
      if (forwarder_rd_en) begin
        issued <= issued + AW'(1);
      end

      case (state)
        S_IDLE: begin
          if (ready_for_forwarder) begin
            state <= S_LATCH;
          end
        end
        S_LATCH: begin
          len_q  <= len_to_forwarder;
          issued <= '0;
          sent   <= '0;
          state  <= (len_to_forwarder == '0) ? S_DONE : S_STREAM;
        end
        S_STREAM: begin
          if (beat && m_axis_tlast) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          pkt_count <= pkt_count + 32'd1;
          state     <= S_HOLD;
        end
        S_HOLD: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
